// File: rtl/uart_tx_engine.sv
// uart_tx_engine: parametrised asynchronous serial transmitter.
// A word offered on Tx_Valid/Tx_Ready is latched with its parity bit.
// The engine holds it until CTS is high, then sends a complete frame on Tx:
// start bit, LSB-first data, optional parity, and one or two stop bits.
// Every bit is timed by an internal baud divider.
module uart_tx_engine #(
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 2,
   parameter int PARITY_MODE  = 1,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [DATA_BITS-1:0] Tx_Data_In,
   input  logic                 Tx_Valid,
   output logic                 Tx_Ready,
   input  logic                 CTS,
   output logic                 Tx,
   output logic                 Tx_Busy,
   output logic                 Tx_Done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   // Reject configurations the frame logic cannot represent
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
      $error("uart_tx_engine: DATA_BITS must be in 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
      $error("uart_tx_engine: STOP_BITS must be 1 or 2");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : gBadParity
      $error("uart_tx_engine: PARITY_MODE must be 0, 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : gBadClks
      $error("uart_tx_engine: CLKS_PER_BIT must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CTS,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q,   state_d;
   logic [BAUD_W-1:0]     baudCnt_q, baudCnt_d;
   logic [BIT_W-1:0]      bitCnt_q,  bitCnt_d;
   logic [DATA_BITS-1:0]  shift_q,   shift_d;
   logic                  parity_q,  parity_d;
   logic                  tx_q,      tx_d;
   logic                  done_q,    done_d;
   logic                  bitEnd;

   assign bitEnd   = (baudCnt_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign Tx       = tx_q;
   assign Tx_Done  = done_q;
   assign Tx_Busy  = (state_q != IDLE);
   assign Tx_Ready = (state_q == IDLE) && Rst_n;

   // Next-state, counter and shift logic; Tx is precomputed from the next
   // state so the pin changes on the same edge the state does
   always_comb begin
      state_d   = state_q;
      baudCnt_d = baudCnt_q;
      bitCnt_d  = bitCnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (Tx_Valid) begin
               shift_d  = Tx_Data_In;
               parity_d = (^Tx_Data_In) ^ (PARITY_MODE == 2);
               state_d  = WAIT_CTS;
            end
         end
         WAIT_CTS: begin
            if (CTS) begin
               baudCnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               bitCnt_d  = '0;
               state_d   = DATA;
            end else begin
               baudCnt_d = baudCnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               shift_d   = shift_q >> 1;
               if (bitCnt_q == BIT_W'(DATA_BITS - 1)) begin
                  bitCnt_d = '0;
                  if (PARITY_MODE != 0) begin
                     state_d = PARITY;
                  end else begin
                     state_d = STOP;
                  end
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end else begin
               baudCnt_d = baudCnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               bitCnt_d  = '0;
               state_d   = STOP;
            end else begin
               baudCnt_d = baudCnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               if (bitCnt_q == BIT_W'(STOP_BITS - 1)) begin
                  bitCnt_d = '0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end else begin
               baudCnt_d = baudCnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_q;
         default: tx_d = 1'b1;
      endcase
   end

   // State register with synchronous active-low reset; reset aborts any frame
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= IDLE;
         baudCnt_q <= '0;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baudCnt_q <= baudCnt_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

   // Line idles high whenever nothing is held or in flight
   aIdleHigh: assert property (@(posedge Clk) disable iff (!Rst_n) !Tx_Busy |-> Tx);
   // Ready and busy are mutually exclusive
   aReadyBusy: assert property (@(posedge Clk) disable iff (!Rst_n) !(Tx_Ready && Tx_Busy));
   // Done is a single-cycle pulse
   aDonePulse: assert property (@(posedge Clk) disable iff (!Rst_n) Tx_Done |=> !Tx_Done);
   // Outputs are always known out of reset
   aNoX: assert property (@(posedge Clk) disable iff (!Rst_n)
                          !$isunknown({Tx, Tx_Busy, Tx_Ready, Tx_Done}));

endmodule
